imem_loader: RTL
================

# imem_loader

Boot-time program loader for the single-cycle processor's instruction memory. Accepts a framed byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian instruction words and writes them sequentially into the instruction memory's write port. It holds the processor core in reset for the whole load and releases it only after a complete, valid image has been written. It is the writer side of the word-addressed instruction store that the core's fetch path reads.

## Interface
Parameters:
- ADDR_W, 6, instruction memory word-address width; DEPTH = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; a transfer occurs on a cycle with rx_valid && rx_ready.
- wr_en  out  1  one-cycle instruction memory write strobe.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  instruction word.
- cpu_reset  out  1  reset to the processor core; high while loading or not loaded.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded successfully.
- error  out  1  last frame rejected.

## Operation
- Frame: SYNC_BYTE, count byte N, then 4*N data bytes (MSB first); with checksum enabled, one trailing checksum byte.
- N = 0 means DEPTH words; N > DEPTH is a frame error.
- States: IDLE, COUNT, BYTES, WRITE, CSUM (macro only), DONE, ERROR.
- IDLE/DONE/ERROR: accept bytes; SYNC_BYTE -> COUNT, clear done/error, set busy, assert cpu_reset, word index = 0; any other byte discarded.
- COUNT: N valid -> BYTES; N invalid -> ERROR.
- BYTES: byte k of word goes to bits [31-8k -: 8]; 4th byte accepted -> WRITE.
- WRITE: wr_en = 1 for exactly one cycle, wr_addr = word index, wr_data = assembled word; index increments; if index was N-1 -> CSUM or DONE, else -> BYTES.
- DONE: done = 1, busy = 0, cpu_reset = 0. ERROR: error = 1, busy = 0, cpu_reset = 1.
- A SYNC_BYTE value inside the data region is treated as data, not a restart.
- Words already written before an error or reset are not undone.

## Timing
- Reset values: rx_ready 1, wr_en 0, wr_addr 0, wr_data 0, cpu_reset 1, busy 0, done 0, error 0; state IDLE.
- rx_ready = 1 in every state except WRITE (0 during that single cycle).
- Latency: 4th data byte accepted at edge t -> wr_en high in cycle t+1.
- Final write at cycle t -> done = 1 and cpu_reset = 0 from cycle t+1 (no checksum).
- Gaps in rx_valid stall the FSM indefinitely; no timeout.
- Reset asserted mid-frame: immediate return to reset values, partial word discarded, no wr_en.
- wr_addr/wr_data hold their last values when wr_en = 0.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last WRITE, the FSM enters CSUM and expects one byte equal to the mod-256 sum of all 4*N data bytes. Match -> DONE; mismatch -> ERROR, cpu_reset stays 1. done/cpu_reset release occur the cycle after the checksum byte is accepted.
- Not defined: no CSUM state; the frame ends at the last WRITE.

## Test plan
- Reset -> rx_ready = 1, cpu_reset = 1, wr_en = 0, done = 0, error = 0.
- Bytes A5 02 8C 01 00 04 AC 02 00 08 -> wr_en at addr 0 data 32'h8C010004, addr 1 data 32'hAC020008; done = 1, cpu_reset = 0 the cycle after the second write.
- Bytes 00 FF 13 then A5 01 00 00 00 20 with random rx_valid gaps -> leading bytes ignored, single write addr 0 data 32'h00000020, done = 1.
- A5 41 -> error = 1, cpu_reset = 1, no wr_en; then A5 01 11 22 33 44 -> error = 0, write 32'h11223344 at addr 0, done = 1.
- A5 01 8C 01 then reset pulse -> no wr_en, all outputs at reset values; a fresh frame afterwards loads normally.
- With IMEM_LOADER_CHECKSUM_EN: A5 01 8C 01 00 04 91 -> done = 1; same with 92 -> error = 1, cpu_reset = 1, word at addr 0 still written.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : framed byte-stream loader for the instruction memory; holds the
//               core in reset until a complete image has been written.
// Option      : define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
// Revision    : 1.0
// ============================================================================
module imem_loader #(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_BYTES = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM = 3'd4
`endif
    } state_t;

    state_t              state_q;
    logic                rx_ready_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [31:0]         wr_data_q;
    logic                cpu_reset_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    idx_q;
    logic [1:0]          byte_q;
    logic [31:0]         word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                rx_fire;
    logic                count_ok;
    logic [CNT_W-1:0]    nwords_d;
    logic [31:0]         word_d;

    assign rx_fire  = rx_valid_i && rx_ready_q;
    assign count_ok = (32'(rx_data_i) <= DEPTH);
    assign nwords_d = (rx_data_i == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(rx_data_i);
    // Bytes arrive MSB first, so shifting left lands byte k at [31-8k -: 8].
    assign word_d   = {word_q[23:0], rx_data_i};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            rx_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
            idx_q       <= '0;
            byte_q      <= 2'd0;
            word_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (rx_fire && rx_data_i == SYNC_BYTE) begin
                        state_q     <= S_COUNT;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        idx_q       <= '0;
                        byte_q      <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q      <= 8'd0;
`endif
                    end
                end
                S_COUNT: begin
                    if (rx_fire) begin
                        if (count_ok) begin
                            count_q <= nwords_d;
                            state_q <= S_BYTES;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_BYTES: begin
                    if (rx_fire) begin
                        word_q <= word_d;
                        byte_q <= byte_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q + rx_data_i;
`endif
                        if (byte_q == 2'd3) begin
                            state_q    <= S_WRITE;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= idx_q[ADDR_W-1:0];
                            wr_data_q  <= word_d;
                            rx_ready_q <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    wr_en_q    <= 1'b0;
                    rx_ready_q <= 1'b1;
                    idx_q      <= idx_q + CNT_W'(1);
                    if (idx_q == count_q - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q     <= S_CSUM;
`else
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cpu_reset_q <= 1'b0;
`endif
                    end else begin
                        state_q <= S_BYTES;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_fire) begin
                        busy_q <= 1'b0;
                        if (rx_data_i == csum_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule
`default_nettype wire
